td4_prog_loader: RTL and testbench

TD4_PROG_LOADER -- requirements
Module: td4_prog_loader

---
 rtl/td4_prog_loader.sv | 135 +++++++++++++
 tb/tb_td4_prog_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/td4_prog_loader.sv
// td4_prog_loader: 16x8 program memory for a TD4 CPU, downloadable from a host byte stream.
// Define TD4_PROG_LOADER_CHECKSUM_EN to require a trailing checksum byte (sum of all 17 bytes == 0).
module td4_prog_loader (
    input  logic       clk,
    input  logic       n_reset,
    input  logic [3:0] address,
    output logic [7:0] instr,
    input  logic       load_start,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    output logic       cpu_n_reset,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LOAD,
        ST_ERROR
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [7:0] mem_q [16];
    logic [7:0] mem_d [16];
    logic       cpu_n_reset_q, cpu_n_reset_d;
    logic       done_q, done_d;
    logic       xfer;
`ifdef TD4_PROG_LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
    logic       err_q, err_d;
`endif

    // State register. cpu_n_reset is registered so it stays low through reset
    // and rises only on the first clock edge after n_reset is released.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= ST_RUN;
            cnt_q         <= '0;
            cpu_n_reset_q <= 1'b0;
            done_q        <= 1'b0;
            // NOTE: the program image must read back as zeros after reset, so the
            // memory is built from resettable flops rather than an inferred RAM.
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= '0;
            end
`ifdef TD4_PROG_LOADER_CHECKSUM_EN
            sum_q         <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge values computed by the combinational block.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cpu_n_reset_q <= cpu_n_reset_d;
            done_q        <= done_d;
            mem_q         <= mem_d;
`ifdef TD4_PROG_LOADER_CHECKSUM_EN
            sum_q         <= sum_d;
            err_q         <= err_d;
`endif
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        mem_d   = mem_q;
        xfer    = load_valid && (state_q == ST_LOAD);
`ifdef TD4_PROG_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
        err_d   = err_q;
`endif

        unique case (state_q)
            ST_RUN, ST_ERROR: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
`ifdef TD4_PROG_LOADER_CHECKSUM_EN
                    sum_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    cnt_d = cnt_q + 5'd1;
                    if (!cnt_q[4]) begin
                        mem_d[cnt_q[3:0]] = load_data;
                    end
`ifdef TD4_PROG_LOADER_CHECKSUM_EN
                    sum_d = sum_q + load_data;
                    if (cnt_q == 5'd16) begin
                        if (sum_d == 8'h00) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_ERROR;
                            err_d   = 1'b1;
                        end
                    end
`else
                    if (cnt_q == 5'd15) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end
`endif
                end
            end
            default: state_d = ST_RUN;
        endcase

        cpu_n_reset_d = (state_d == ST_RUN);
    end

    // Outputs. instr reads the pre-edge memory contents during a same-cycle write.
    always_comb begin
        instr       = mem_q[address];
        load_ready  = (state_q == ST_LOAD);
        cpu_n_reset = cpu_n_reset_q;
        done        = done_q;
`ifdef TD4_PROG_LOADER_CHECKSUM_EN
        err         = err_q;
`else
        err         = 1'b0;
`endif
    end

endmodule

// File: tb/tb_td4_prog_loader.sv
// Directed bench for td4_prog_loader: readback vector tables plus download sequences
// (back-to-back, stalled, restart request, mid-download reset, checksum when enabled).
module tb_td4_prog_loader;

    logic       clk = 1'b0;
    logic       n_reset;
    logic [3:0] address;
    logic [7:0] instr;
    logic       load_start;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic       cpu_n_reset;
    logic       done;
    logic       err;

`ifdef TD4_PROG_LOADER_CHECKSUM_EN
    localparam int NB = 17;
`else
    localparam int NB = 16;
`endif

    typedef struct {
        logic [3:0] addr;
        logic [7:0] exp_instr;
    } rd_vec_t;

    rd_vec_t    rd_vec [16];
    logic [7:0] exp_mem [16];
    logic [7:0] dl_bytes [17];
    int         n_tests = 0;
    int         n_fail  = 0;

    td4_prog_loader dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .address     (address),
        .instr       (instr),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .cpu_n_reset (cpu_n_reset),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic readback(input string tag);
        for (int i = 0; i < 16; i++) begin
            address = rd_vec[i].addr;
            #1;
            check($sformatf("%s instr[%0d]", tag, rd_vec[i].addr), instr, rd_vec[i].exp_instr);
        end
    endtask

    // Full download of dl_bytes[0..NB-1]; gap idle cycles between bytes, optional
    // second load_start after restart_at bytes, ok selects success or checksum failure.
    task automatic download(input int gap, input int restart_at, input logic ok, input string tag);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check({tag, " ready after start"}, load_ready, 1);
        check({tag, " cpu held after start"}, cpu_n_reset, 0);
        check({tag, " err cleared"}, err, 0);
        for (int k = 0; k < NB; k++) begin
            if (k == restart_at) begin
                load_start = 1'b1;
                load_valid = 1'b0;
                step();
                load_start = 1'b0;
                check({tag, " ready after restart req"}, load_ready, 1);
                check({tag, " cpu held after restart req"}, cpu_n_reset, 0);
            end
            if (k > 0) begin
                for (int g = 0; g < gap; g++) begin
                    load_valid = 1'b0;
                    load_data  = 8'hEE;
                    step();
                    check({tag, " ready in stall"}, load_ready, 1);
                    check({tag, " cpu held in stall"}, cpu_n_reset, 0);
                end
            end
            load_valid = 1'b1;
            load_data  = dl_bytes[k];
            if (k < 16) begin
                address = 4'(k);
                #1;
                check($sformatf("%s pre-edge instr[%0d]", tag, k), instr, exp_mem[k]);
            end
            step();
            load_valid = 1'b0;
            if (k < 16) begin
                exp_mem[k] = dl_bytes[k];
                check($sformatf("%s written instr[%0d]", tag, k), instr, exp_mem[k]);
            end
            if (k < NB - 1) begin
                check($sformatf("%s no done at byte %0d", tag, k), done, 0);
                check($sformatf("%s ready at byte %0d", tag, k), load_ready, 1);
            end
        end
        if (ok) begin
            check({tag, " done pulse"}, done, 1);
            check({tag, " cpu released"}, cpu_n_reset, 1);
            check({tag, " ready low in RUN"}, load_ready, 0);
            check({tag, " err low"}, err, 0);
            step();
            check({tag, " done one cycle"}, done, 0);
            check({tag, " cpu stays released"}, cpu_n_reset, 1);
        end else begin
            check({tag, " no done"}, done, 0);
            check({tag, " err set"}, err, 1);
            check({tag, " cpu held in error"}, cpu_n_reset, 0);
            check({tag, " ready low in error"}, load_ready, 0);
            step();
            step();
            check({tag, " err held"}, err, 1);
            check({tag, " cpu still held"}, cpu_n_reset, 0);
            check({tag, " still no done"}, done, 0);
        end
    endtask

    initial begin
        n_reset    = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        address    = 4'd0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;

        // Reset state
        #12;
        check("reset cpu_n_reset", cpu_n_reset, 0);
        check("reset load_ready", load_ready, 0);
        check("reset done", done, 0);
        check("reset err", err, 0);
        @(negedge clk);
        n_reset = 1'b1;
        #1;
        check("cpu held before first edge", cpu_n_reset, 0);
        step();
        check("cpu released after first edge", cpu_n_reset, 1);
        check("idle done", done, 0);
        check("idle err", err, 0);
        check("idle load_ready", load_ready, 0);
        for (int i = 0; i < 16; i++) rd_vec[i] = '{addr: 4'(i), exp_instr: 8'h00};
        readback("idle");

        // Back-to-back download of 0x01..0x10
        for (int k = 0; k < 16; k++) dl_bytes[k] = 8'(k + 1);
        dl_bytes[16] = 8'h78;
        download(0, -1, 1'b1, "dl1");
        for (int i = 0; i < 16; i++) rd_vec[i] = '{addr: 4'(15 - i), exp_instr: 8'(16 - i)};
        readback("dl1");
        address = 4'd10;
        #1;
        check("dl1 instr at 10", instr, 8'h0B);

        // Download 0xA0..0xAF with a second load_start after 8 bytes
        for (int k = 0; k < 16; k++) dl_bytes[k] = 8'(8'hA0 + k);
        dl_bytes[16] = 8'h88;
        download(0, 8, 1'b1, "dl2_restart");
        for (int i = 0; i < 16; i++) rd_vec[i] = '{addr: 4'(i), exp_instr: 8'(8'hA0 + i)};
        readback("dl2");

        // Stalled download: 3 idle cycles between bytes
        for (int k = 0; k < 16; k++) dl_bytes[k] = 8'(k + 1);
        dl_bytes[16] = 8'h78;
        download(3, -1, 1'b1, "dl3_stall");
        for (int i = 0; i < 16; i++) rd_vec[i] = '{addr: 4'(i), exp_instr: 8'(i + 1)};
        readback("dl3");

`ifdef TD4_PROG_LOADER_CHECKSUM_EN
        // Bad checksum, then recovery with a correct download
        for (int k = 0; k < 16; k++) dl_bytes[k] = 8'(8'hA0 + k);
        dl_bytes[16] = 8'h87;
        download(0, -1, 1'b0, "dl_bad_sum");
        for (int i = 0; i < 16; i++) rd_vec[i] = '{addr: 4'(i), exp_instr: 8'(8'hA0 + i)};
        readback("dl_bad_sum");
        for (int k = 0; k < 16; k++) dl_bytes[k] = 8'(k + 1);
        dl_bytes[16] = 8'h77;
        download(0, -1, 1'b0, "dl_bad_77");
        dl_bytes[16] = 8'h78;
        download(0, -1, 1'b1, "dl_good");
`endif

        // Reset after 5 accepted bytes
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            load_valid = 1'b1;
            load_data  = 8'(8'hC0 + k);
            step();
        end
        load_valid = 1'b0;
        address = 4'd4;
        #1;
        check("partial byte 4 written", instr, 8'hC4);
        address = 4'd5;
        #1;
        check("partial byte 5 untouched", instr, 8'h06);
        n_reset = 1'b0;
        #1;
        check("mid reset load_ready", load_ready, 0);
        check("mid reset cpu held", cpu_n_reset, 0);
        check("mid reset done", done, 0);
        for (int i = 0; i < 16; i++) rd_vec[i] = '{addr: 4'(i), exp_instr: 8'h00};
        readback("mid_reset");
        @(negedge clk);
        n_reset = 1'b1;
        step();
        check("post reset cpu released", cpu_n_reset, 1);
        check("post reset load_ready", load_ready, 0);
        check("post reset err", err, 0);

        // load_valid while in RUN must not write
        load_valid = 1'b1;
        load_data  = 8'h55;
        address    = 4'd0;
        step();
        load_valid = 1'b0;
        check("RUN valid ignored instr[0]", instr, 8'h00);
        check("RUN valid ready low", load_ready, 0);
        check("RUN valid no done", done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
